// File: rtl/scr1_axi_rd_arbiter.sv
// N-master to 1-slave AXI read arbiter: round-robin AR merge with master index
// prepended to the ID, ID-routed R return, and an outstanding-burst limiter.
module scr1_axi_rd_arbiter #(
    parameter int  N_MST     = 2,
    parameter int  MID_W     = 3,
    parameter int  ADDR_W    = 32,
    parameter int  DATA_W    = 32,
    parameter int  MAX_OUTST = 4,
    localparam int SID_W     = MID_W + $clog2(N_MST)
) (
    input  logic                      clk_riscv,
    input  logic                      rstn_riscv,
    input  logic [N_MST*MID_W-1:0]    m_arid,
    input  logic [N_MST*ADDR_W-1:0]   m_araddr,
    input  logic [N_MST*8-1:0]        m_arlen,
    input  logic [N_MST*3-1:0]        m_arsize,
    input  logic [N_MST*2-1:0]        m_arburst,
    input  logic [N_MST-1:0]          m_arvalid,
    output logic [N_MST-1:0]          m_arready,
    output logic [N_MST*MID_W-1:0]    m_rid,
    output logic [N_MST*DATA_W-1:0]   m_rdata,
    output logic [N_MST*2-1:0]        m_rresp,
    output logic [N_MST-1:0]          m_rlast,
    output logic [N_MST-1:0]          m_rvalid,
    input  logic [N_MST-1:0]          m_rready,
    output logic [SID_W-1:0]          s_arid,
    output logic [ADDR_W-1:0]         s_araddr,
    output logic [7:0]                s_arlen,
    output logic [2:0]                s_arsize,
    output logic [1:0]                s_arburst,
    output logic                      s_arvalid,
    input  logic                      s_arready,
    input  logic [SID_W-1:0]          s_rid,
    input  logic [DATA_W-1:0]         s_rdata,
    input  logic [1:0]                s_rresp,
    input  logic                      s_rlast,
    input  logic                      s_rvalid,
    output logic                      s_rready,
    output logic [3:0]                outst_cnt,
    output logic                      err_unmapped
);

    localparam int IDX_W = SID_W - MID_W;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } ar_state_t;

    ar_state_t           r_state;
    ar_state_t           w_next_state;
    logic [IDX_W-1:0]    r_last_grant;
    logic [IDX_W-1:0]    w_grant;
    logic                w_grant_vld;
    logic                w_room;
    logic                w_accept;
    logic                w_ar_hs;

    logic [SID_W-1:0]    r_arid;
    logic [ADDR_W-1:0]   r_araddr;
    logic [7:0]          r_arlen;
    logic [2:0]          r_arsize;
    logic [1:0]          r_arburst;

    logic [3:0]          r_outst_cnt;
    logic                r_err_unmapped;
    logic [IDX_W-1:0]    w_ridx;
    logic                w_unmapped;
    logic                w_r_last_hs;

    assign w_room   = r_outst_cnt < 4'(MAX_OUTST);
    assign w_accept = (r_state == ST_IDLE) && w_grant_vld && w_room;
    assign w_ar_hs  = (r_state == ST_ISSUE) && s_arready;

    // Round-robin: walk from the highest offset down so the nearest requester
    // after last_grant is the final (winning) assignment.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_grant     = r_last_grant;
        w_grant_vld = 1'b0;
        for (int i = N_MST; i >= 1; i--) begin
            if (m_arvalid[(int'(r_last_grant) + i) % N_MST]) begin
                w_grant     = IDX_W'((int'(r_last_grant) + i) % N_MST);
                w_grant_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_riscv or negedge rstn_riscv) begin
        // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
        if (!rstn_riscv) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_next_state = ST_ISSUE;
            ST_ISSUE: if (s_arready) w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // m_arready is gated by reset because IDLE is also the reset state.
    always_comb begin
        m_arready = '0;
        s_arvalid = 1'b0;
        case (r_state)
            ST_IDLE:  if (w_accept && rstn_riscv) m_arready[w_grant] = 1'b1;
            ST_ISSUE: s_arvalid = 1'b1;
            default:  s_arvalid = 1'b0;
        endcase
    end

    always_ff @(posedge clk_riscv or negedge rstn_riscv) begin
        if (!rstn_riscv) begin
            r_arid       <= '0;
            r_araddr     <= '0;
            r_arlen      <= '0;
            r_arsize     <= '0;
            r_arburst    <= '0;
            r_last_grant <= IDX_W'(N_MST - 1);
        end else begin
            if (w_accept) begin
                r_arid    <= {w_grant, m_arid[w_grant*MID_W +: MID_W]};
                r_araddr  <= m_araddr[w_grant*ADDR_W +: ADDR_W];
                r_arlen   <= m_arlen[w_grant*8 +: 8];
                r_arsize  <= m_arsize[w_grant*3 +: 3];
                r_arburst <= m_arburst[w_grant*2 +: 2];
            end
            // The grant index is already held in the upper bits of the merged ID.
            if (w_ar_hs) r_last_grant <= r_arid[SID_W-1:MID_W];
        end
    end

    assign s_arid    = r_arid;
    assign s_araddr  = r_araddr;
    assign s_arlen   = r_arlen;
    assign s_arsize  = r_arsize;
    assign s_arburst = r_arburst;

    assign w_ridx      = s_rid[SID_W-1:MID_W];
    assign w_unmapped  = int'(w_ridx) >= N_MST;
    assign w_r_last_hs = s_rvalid && s_rready && s_rlast;

    assign m_rid   = {N_MST{s_rid[MID_W-1:0]}};
    assign m_rdata = {N_MST{s_rdata}};
    assign m_rresp = {N_MST{s_rresp}};
    assign m_rlast = {N_MST{s_rlast}};

    // Unmapped beats are swallowed so a bad ID can never stall the slave.
    always_comb begin
        m_rvalid = '0;
        s_rready = w_unmapped;
        for (int m = 0; m < N_MST; m++) begin
            if (!w_unmapped && int'(w_ridx) == m) begin
                m_rvalid[m] = s_rvalid;
                s_rready    = m_rready[m];
            end
        end
    end

    always_ff @(posedge clk_riscv or negedge rstn_riscv) begin
        if (!rstn_riscv) begin
            r_outst_cnt    <= '0;
            r_err_unmapped <= 1'b0;
        end else begin
            case ({w_ar_hs, w_r_last_hs})
                2'b10:   if (r_outst_cnt != 4'hF) r_outst_cnt <= r_outst_cnt + 4'd1;
                2'b01:   if (r_outst_cnt != 4'h0) r_outst_cnt <= r_outst_cnt - 4'd1;
                default: r_outst_cnt <= r_outst_cnt;
            endcase
            if (s_rvalid && w_unmapped) r_err_unmapped <= 1'b1;
        end
    end

    assign outst_cnt    = r_outst_cnt;
    assign err_unmapped = r_err_unmapped;

endmodule

// File: tb/tb_scr1_axi_rd_arbiter.sv
// Scoreboard bench for scr1_axi_rd_arbiter with three masters, so the 2-bit
// master index can also carry the unmapped value 3.
module tb_scr1_axi_rd_arbiter;

    localparam int N         = 3;
    localparam int MID_W     = 3;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int MAX_OUTST = 4;
    localparam int SID_W     = MID_W + 2;

    logic                  clk_riscv = 1'b0;
    logic                  rstn_riscv = 1'b0;
    logic [N*MID_W-1:0]    m_arid = '0;
    logic [N*ADDR_W-1:0]   m_araddr = '0;
    logic [N*8-1:0]        m_arlen = '0;
    logic [N*3-1:0]        m_arsize = '0;
    logic [N*2-1:0]        m_arburst = '0;
    logic [N-1:0]          m_arvalid = '0;
    logic [N-1:0]          m_arready;
    logic [N*MID_W-1:0]    m_rid;
    logic [N*DATA_W-1:0]   m_rdata;
    logic [N*2-1:0]        m_rresp;
    logic [N-1:0]          m_rlast;
    logic [N-1:0]          m_rvalid;
    logic [N-1:0]          m_rready = '1;
    logic [SID_W-1:0]      s_arid;
    logic [ADDR_W-1:0]     s_araddr;
    logic [7:0]            s_arlen;
    logic [2:0]            s_arsize;
    logic [1:0]            s_arburst;
    logic                  s_arvalid;
    logic                  s_arready = 1'b0;
    logic [SID_W-1:0]      s_rid = '0;
    logic [DATA_W-1:0]     s_rdata = '0;
    logic [1:0]            s_rresp = '0;
    logic                  s_rlast = 1'b0;
    logic                  s_rvalid = 1'b0;
    logic                  s_rready;
    logic [3:0]            outst_cnt;
    logic                  err_unmapped;

    always #5 clk_riscv = ~clk_riscv;

    scr1_axi_rd_arbiter #(
        .N_MST(N), .MID_W(MID_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUTST(MAX_OUTST)
    ) dut (
        .clk_riscv(clk_riscv), .rstn_riscv(rstn_riscv),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready),
        .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready),
        .outst_cnt(outst_cnt), .err_unmapped(err_unmapped)
    );

    typedef struct {
        logic [SID_W-1:0]  id;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
    } ar_exp_t;

    typedef struct {
        int                mst;
        logic [MID_W-1:0]  id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
    } r_exp_t;

    ar_exp_t          arq[$];
    r_exp_t           rq[$];
    int               grant_log[$];

    int               n_checks = 0;
    int               n_fail = 0;
    int               cyc = 0;
    int               last_acc = -100;
    int               acc_cnt = 0;
    int               mdl_last = N - 1;
    int               mdl_outst = 0;
    bit               mdl_err = 1'b0;
    bit               r_hs = 1'b0;
    bit               tog = 1'b0;

    int               n_left[N];
    bit               adv[N];
    logic [MID_W-1:0] req_id[N];
    logic [ADDR_W-1:0] req_addr[N];
    logic [7:0]       req_len[N];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int last);
        for (int i = 1; i <= N; i++) begin
            if (v[(last + i) % N]) return (last + i) % N;
        end
        return -1;
    endfunction

    task automatic drive_masters();
        for (int m = 0; m < N; m++) begin
            m_arvalid[m]                = (n_left[m] > 0);
            m_arid[m*MID_W +: MID_W]    = req_id[m];
            m_araddr[m*ADDR_W +: ADDR_W] = req_addr[m];
            m_arlen[m*8 +: 8]           = req_len[m];
            m_arsize[m*3 +: 3]          = 3'(m);
            m_arburst[m*2 +: 2]         = 2'b01;
        end
    endtask

    task automatic set_req(input int m, input int n, input logic [ADDR_W-1:0] addr);
        n_left[m]   = n;
        req_addr[m] = addr;
        req_id[m]   = MID_W'(m + 1);
        req_len[m]  = 8'(m * 2 + 1);
        drive_masters();
    endtask

    // Compare current outputs against the model, then fold this cycle's
    // handshakes into the model (they commit at the coming rising edge).
    task automatic monitor();
        logic [1:0]   sidx;
        logic [N-1:0] exp_rv;
        logic         exp_rr;
        int           eg;
        ar_exp_t      ea;
        r_exp_t       er;
        sidx = s_rid[SID_W-1:MID_W];
        check("outst_cnt", 64'(outst_cnt), 64'(mdl_outst));
        check("err_unmapped", 64'(err_unmapped), 64'(mdl_err));

        if (m_arready != '0) begin
            eg = pick(m_arvalid, mdl_last);
            check("ar_grant", 64'(m_arready), (eg >= 0) ? 64'(1 << eg) : 64'(0));
            check("ar_spacing", 64'(cyc - last_acc >= 2), 64'(1));
            if (eg >= 0) begin
                arq.push_back('{id: {2'(eg), req_id[eg]}, addr: req_addr[eg],
                                len: req_len[eg], size: 3'(eg)});
                adv[eg]  = 1'b1;
                mdl_last = eg;
                grant_log.push_back(eg);
            end
            last_acc = cyc;
            acc_cnt++;
        end

        if (s_arvalid && !s_arready && arq.size() > 0) begin
            check("ar_stable_id", 64'(s_arid), 64'(arq[0].id));
            check("ar_stable_addr", 64'(s_araddr), 64'(arq[0].addr));
        end
        if (s_arvalid && s_arready) begin
            if (arq.size() == 0) begin
                check("ar_unexpected", 64'(1), 64'(0));
            end else begin
                ea = arq.pop_front();
                check("s_arid", 64'(s_arid), 64'(ea.id));
                check("s_araddr", 64'(s_araddr), 64'(ea.addr));
                check("s_arlen", 64'(s_arlen), 64'(ea.len));
                check("s_arsize", 64'(s_arsize), 64'(ea.size));
                check("s_arburst", 64'(s_arburst), 64'(2'b01));
            end
            mdl_outst++;
        end

        exp_rv = '0;
        if (s_rvalid && sidx < 2'(N)) exp_rv[sidx] = 1'b1;
        check("m_rvalid", 64'(m_rvalid), 64'(exp_rv));
        if (s_rvalid) begin
            exp_rr = (sidx >= 2'(N)) ? 1'b1 : m_rready[sidx];
            check("s_rready", 64'(s_rready), 64'(exp_rr));
            if (exp_rr) begin
                r_hs = 1'b1;
                if (s_rlast && mdl_outst > 0) mdl_outst--;
                if (sidx >= 2'(N)) mdl_err = 1'b1;
            end
        end
        for (int m = 0; m < N; m++) begin
            if (m_rvalid[m] && m_rready[m]) begin
                if (rq.size() == 0) begin
                    check("r_unexpected", 64'(1), 64'(0));
                end else begin
                    er = rq.pop_front();
                    check("r_master", 64'(m), 64'(er.mst));
                    check("m_rid", 64'(m_rid[m*MID_W +: MID_W]), 64'(er.id));
                    check("m_rdata", 64'(m_rdata[m*DATA_W +: DATA_W]), 64'(er.data));
                    check("m_rresp", 64'(m_rresp[m*2 +: 2]), 64'(er.resp));
                    check("m_rlast", 64'(m_rlast[m]), 64'(er.last));
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk_riscv);
        monitor();
        @(posedge clk_riscv);
        #1;
        cyc++;
        for (int m = 0; m < N; m++) begin
            if (adv[m]) begin
                adv[m]      = 1'b0;
                n_left[m]   = n_left[m] - 1;
                req_addr[m] = req_addr[m] + 32'h100;
                req_id[m]   = req_id[m] + 1'b1;
            end
        end
        drive_masters();
        if (tog) m_rready[1] = ~m_rready[1];
    endtask

    task automatic wait_acc(input int target, input int budget);
        for (int k = 0; k < budget && acc_cnt < target; k++) tick();
        check("wait_acc", 64'(acc_cnt), 64'(target));
    endtask

    task automatic wait_issue(input int budget);
        for (int k = 0; k < budget && !s_arvalid; k++) tick();
        check("wait_issue", 64'(s_arvalid), 64'(1));
    endtask

    task automatic r_beat(input logic [1:0] idx, input logic [MID_W-1:0] id,
                          input logic [DATA_W-1:0] data, input logic last);
        s_rvalid = 1'b1;
        s_rid    = {idx, id};
        s_rdata  = data;
        s_rresp  = data[1:0];
        s_rlast  = last;
        if (idx < 2'(N)) rq.push_back('{mst: int'(idx), id: id, data: data, resp: data[1:0], last: last});
        r_hs = 1'b0;
        for (int k = 0; k < 40 && !r_hs; k++) tick();
        check("r_beat_done", 64'(r_hs), 64'(1));
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
    endtask

    initial begin
        int exp_ord[4] = '{0, 1, 0, 1};
        int target;
        for (int m = 0; m < N; m++) begin
            n_left[m] = 0; adv[m] = 1'b0; req_id[m] = '0; req_addr[m] = '0; req_len[m] = '0;
        end
        drive_masters();

        // Reset state
        repeat (3) tick();
        check("rst_s_arvalid", 64'(s_arvalid), 64'(0));
        check("rst_m_arready", 64'(m_arready), 64'(0));
        check("rst_s_arid", 64'(s_arid), 64'(0));
        check("rst_s_araddr", 64'(s_araddr), 64'(0));
        rstn_riscv = 1'b1;

        // Two competing masters alternate grants
        s_arready = 1'b1;
        set_req(0, 2, 32'h1000);
        set_req(1, 2, 32'h2000);
        wait_acc(4, 40);
        repeat (3) tick();
        check("rr_count", 64'(grant_log.size()), 64'(4));
        for (int i = 0; i < 4 && i < grant_log.size(); i++)
            check("rr_order", 64'(grant_log[i]), 64'(exp_ord[i]));
        check("outst_full", 64'(outst_cnt), 64'(4));

        // Limit reached: no further acceptance until one burst completes
        set_req(2, 1, 32'h3000);
        repeat (10) tick();
        check("stall_acc", 64'(acc_cnt), 64'(4));
        check("stall_arready", 64'(m_arready), 64'(0));
        r_beat(2'd0, 3'd1, 32'h0000_00A0, 1'b1);
        wait_acc(5, 20);
        repeat (3) tick();
        check("outst_refill", 64'(outst_cnt), 64'(4));

        // 4-beat burst to master 1 with its rready toggling
        tog = 1'b1;
        for (int b = 0; b < 4; b++) r_beat(2'd1, 3'd5, 32'hB000 + 32'(b), b == 3);
        tog = 1'b0;
        m_rready = '1;
        repeat (2) tick();
        check("outst_after_burst", 64'(outst_cnt), 64'(3));

        // Simultaneous AR and R-last handshakes leave the count unchanged
        r_beat(2'd0, 3'd2, 32'h0000_00C1, 1'b1);
        repeat (2) tick();
        check("outst_two", 64'(outst_cnt), 64'(2));
        s_arready = 1'b0;
        set_req(0, 1, 32'h4000);
        wait_issue(20);
        repeat (2) tick();
        s_arready = 1'b1;
        r_beat(2'd0, 3'd3, 32'h0000_00D2, 1'b1);
        tick();
        check("outst_same", 64'(outst_cnt), 64'(2));

        // Unmapped master index: dropped, flagged, still counted
        m_rready = '0;
        r_beat(2'd3, 3'd0, 32'h0000_00E3, 1'b1);
        repeat (3) tick();
        check("err_set", 64'(err_unmapped), 64'(1));
        check("outst_unmapped", 64'(outst_cnt), 64'(1));
        m_rready = '1;

        // Reset while an AR is stalled in ISSUE
        s_arready = 1'b0;
        set_req(1, 1, 32'h5000);
        wait_issue(20);
        rstn_riscv = 1'b0;
        #1;
        check("rst_async_arvalid", 64'(s_arvalid), 64'(0));
        check("rst_async_outst", 64'(outst_cnt), 64'(0));
        check("rst_async_err", 64'(err_unmapped), 64'(0));
        mdl_outst = 0;
        mdl_err   = 1'b0;
        mdl_last  = N - 1;
        arq.delete();
        rq.delete();
        for (int m = 0; m < N; m++) begin
            n_left[m] = 0;
            adv[m]    = 1'b0;
        end
        drive_masters();
        repeat (2) tick();
        rstn_riscv = 1'b1;
        grant_log.delete();
        s_arready = 1'b1;
        set_req(0, 1, 32'h6000);
        set_req(1, 1, 32'h7000);
        target = acc_cnt + 2;
        wait_acc(target, 20);
        repeat (3) tick();
        check("post_rst_first", (grant_log.size() > 0) ? 64'(grant_log[0]) : 64'hFF, 64'(0));
        check("post_rst_outst", 64'(outst_cnt), 64'(2));

        check("arq_empty", 64'(arq.size()), 64'(0));
        check("rq_empty", 64'(rq.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/scr1_axi_rd_arbiter.md
SCR1_AXI_RD_ARBITER -- requirements
Module: scr1_axi_rd_arbiter

Interface
REQ-001 SHALL have parameter N_MST, default 2, number of AXI read masters (2..8).
REQ-002 SHALL have parameter MID_W, default 3, master-side ID width.
REQ-003 SHALL have parameter ADDR_W, default 32, address width.
REQ-004 SHALL have parameter DATA_W, default 32, data width.
REQ-005 SHALL have parameter MAX_OUTST, default 4, max outstanding bursts in total (1..15).
REQ-006 SHALL define local SID_W = MID_W + clog2(N_MST), the slave-side ID width.
REQ-007 SHALL have ports, listed clock and reset first:
- clk_riscv  in  1  clock
- rstn_riscv  in  1  reset, asynchronous, active-low
- m_arid  in  N_MST*MID_W  per-master AR ID
- m_araddr  in  N_MST*ADDR_W  AR address
- m_arlen  in  N_MST*8  burst length
- m_arsize  in  N_MST*3  burst size
- m_arburst  in  N_MST*2  burst type
- m_arvalid  in  N_MST  AR valid
- m_arready  out  N_MST  AR ready
- m_rid  out  N_MST*MID_W  R ID
- m_rdata  out  N_MST*DATA_W  R data
- m_rresp  out  N_MST*2  R response
- m_rlast  out  N_MST  R last
- m_rvalid  out  N_MST  R valid
- m_rready  in  N_MST  R ready
- s_arid / s_araddr / s_arlen / s_arsize / s_arburst  out  SID_W / ADDR_W / 8 / 3 / 2  merged AR fields
- s_arvalid  out  1; s_arready  in  1
- s_rid  in  SID_W; s_rdata  in  DATA_W; s_rresp  in  2; s_rlast  in  1; s_rvalid  in  1; s_rready  out  1
- outst_cnt  out  4  current outstanding-burst count
- err_unmapped  out  1  sticky: R beat carried a master index >= N_MST

Function
REQ-008 AR FSM SHALL have two states, IDLE and ISSUE.
REQ-009 IDLE -> ISSUE when any m_arvalid is set and outst_cnt < MAX_OUTST; the arbiter SHALL pick the grant round-robin, starting from the index after last_grant, and assert m_arready[grant] for exactly that cycle.
REQ-010 On IDLE->ISSUE, the AR fields of the granted master SHALL be registered; s_arid SHALL equal {grant index, m_arid[grant]}.
REQ-011 In ISSUE, s_arvalid SHALL be 1 and the registered fields SHALL remain stable until s_arready; on handshake the FSM SHALL go to IDLE and last_grant SHALL be set to grant.
REQ-012 m_arready SHALL be 0 in ISSUE; the minimum spacing between AR acceptances SHALL be 2 cycles.
REQ-013 outst_cnt SHALL increment on the s_ar handshake and decrement on an s_r handshake with s_rlast; if both occur in the same cycle it SHALL be unchanged; it SHALL never wrap.
REQ-014 R path SHALL be combinational, with idx = s_rid[SID_W-1:MID_W]: m_rvalid[idx] = s_rvalid, s_rready = m_rready[idx], and m_rid/m_rdata/m_rresp/m_rlast[idx] taken from the slave; all other m_rvalid SHALL be 0.
REQ-015 If idx >= N_MST: s_rready SHALL be 1 (beat dropped), err_unmapped SHALL be set until reset, and outst_cnt SHALL still decrement on rlast.
REQ-016 A master dropping m_arvalid before it is granted SHALL be permitted; no grant SHALL be issued to a master with m_arvalid = 0.

Reset
REQ-017 While rstn_riscv = 0: FSM = IDLE, s_arvalid = 0, m_arready = 0, outst_cnt = 0, err_unmapped = 0, last_grant = N_MST-1 (master 0 wins first), registered AR fields = 0.
REQ-018 Reset asserted mid-burst SHALL abandon all transactions with no completion tracking; after release, the block SHALL behave as from power-up.

Verification
REQ-019 Master0 and master1 arvalid asserted together, s_arready = 1 -> grants in order 0,1,0,1; s_arid = {1'b0,id0} then {1'b1,id1}; 2-cycle spacing.
REQ-020 MAX_OUTST = 4, slave never returns R -> exactly 4 ARs issued, outst_cnt = 4, m_arready stays 0 afterwards; one rlast beat -> outst_cnt = 3 and the next AR is accepted.
REQ-021 s_rid = {1'b1,3'd5}, 4-beat burst, m_rready[1] toggling -> beats delivered only to master1 with m_rid[1] = 5; s_rready follows m_rready[1]; master0 sees no rvalid.
REQ-022 Same cycle s_ar handshake and s_rlast handshake with outst_cnt = 2 -> outst_cnt stays 2.
REQ-023 N_MST = 3, s_rid index = 3 with rlast -> s_rready = 1, err_unmapped = 1 until reset, outst_cnt decrements.
REQ-024 Reset pulsed while in ISSUE with s_arready = 0 -> s_arvalid = 0 and outst_cnt = 0 immediately; first post-reset grant goes to master0.
